// File: rtl/lab_pkg.sv
// rtl/lab_pkg.sv - shared ROM geometry constants and streamer state encoding
package lab_pkg;

    localparam int ROM_ADDR_W = 3;
    localparam int ROM_DATA_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } rom_stream_state_t;

endpackage

// File: rtl/lab_rom.sv
// rtl/lab_rom.sv - 8 x 4 combinational lookup ROM holding address+1
//
// Ports:
//   adr  - read address
//   data - word at adr, combinational
module lab_rom
    import lab_pkg::*;
(
    input  logic [ROM_ADDR_W-1:0] adr,
    output logic [ROM_DATA_W-1:0] data
);

    always_comb begin
        data = ROM_DATA_W'(adr) + ROM_DATA_W'(1);
    end

endmodule

// File: rtl/rom_streamer.sv
// rtl/rom_streamer.sv - walks every ROM address and streams the words with a checksum
//
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   start, abort         - begin a scan (IDLE only) / cancel a scan in progress
//   rom_adr, rom_data    - ROM address out, combinational ROM data in
//   out_data, out_valid,
//   out_ready, out_last  - valid/ready word stream, last marks the final address
//   busy, done           - scan in progress / one-cycle completion pulse
//   sum                  - running total of accepted words, held after done
module rom_streamer
    import lab_pkg::*;
#(
    parameter int ADDR_W = ROM_ADDR_W,
    parameter int DATA_W = ROM_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    output logic [ADDR_W-1:0]        rom_adr,
    input  logic [DATA_W-1:0]        rom_data,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_W+ADDR_W-1:0] sum
);

    localparam logic [ADDR_W-1:0] LAST_ADR = '1;

    rom_stream_state_t state;
    logic              xfer;

    // out_valid is only ever high in STREAM, so it doubles as the handshake qualifier.
    assign xfer     = out_valid & out_ready;
    assign out_data = out_valid ? rom_data : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rom_adr   <= '0;
            sum       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= STREAM;
                        rom_adr   <= '0;
                        sum       <= '0;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        out_last  <= (LAST_ADR == '0);
                    end
                end

                STREAM: begin
                    // A word accepted on the abort edge still counts toward the checksum.
                    if (xfer) begin
                        sum <= sum + {{ADDR_W{1'b0}}, rom_data};
                    end
                    if (abort) begin
                        state     <= IDLE;
                        rom_adr   <= '0;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        busy      <= 1'b0;
                    end else if (xfer) begin
                        if (out_last) begin
                            state     <= DONE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            rom_adr  <= rom_adr + 1'b1;
                            out_last <= (rom_adr + 1'b1 == LAST_ADR);
                        end
                    end
                end

                DONE: begin
                    // Final address is held through DONE, then parked at 0 for the next scan.
                    state   <= IDLE;
                    rom_adr <= '0;
                end

                default: begin
                    state     <= IDLE;
                    rom_adr   <= '0;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_streamer.sv
// tb/tb_rom_streamer.sv - self-checking bench for rom_streamer with the lookup ROM
module tb_rom_streamer;
    import lab_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       out_ready;
    logic [2:0] rom_adr;
    logic [3:0] rom_data;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       busy;
    logic       done;
    logic [6:0] sum;

    int total = 0;
    int bad   = 0;

    // Reference: phase 0 = idle, 1 = streaming, 2 = completion cycle.
    int m_phase;
    int m_idx;
    int m_sum;
    int acc[$];

    lab_rom u_rom (
        .adr  (rom_adr),
        .data (rom_data)
    );

    rom_streamer u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .rom_adr   (rom_adr),
        .rom_data  (rom_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .sum       (sum)
    );

    always #5 clk = ~clk;

    function automatic int table_word(int a);
        return a + 1;
    endfunction

    task automatic chk(string tag, int obs, int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_idx   = 0;
        m_sum   = 0;
    endtask

    task automatic check_outputs();
        chk("out_valid", int'(out_valid), int'(m_phase == 1));
        chk("busy",      int'(busy),      int'(m_phase == 1));
        chk("done",      int'(done),      int'(m_phase == 2));
        chk("out_last",  int'(out_last),  int'(m_phase == 1 && m_idx == 7));
        chk("out_data",  int'(out_data),  (m_phase == 1) ? table_word(m_idx) : 0);
        chk("rom_adr",   int'(rom_adr),   m_idx);
        chk("sum",       int'(sum),       m_sum);
    endtask

    // Apply inputs for one cycle, check current outputs, advance the reference, cross the edge.
    task automatic step(bit s, bit a, bit r);
        start     = s;
        abort     = a;
        out_ready = r;
        check_outputs();
        case (m_phase)
            0: if (s) begin
                m_phase = 1;
                m_idx   = 0;
                m_sum   = 0;
            end
            1: begin
                if (r) begin
                    m_sum += table_word(m_idx);
                    acc.push_back(table_word(m_idx));
                end
                if (a) begin
                    m_phase = 0;
                    m_idx   = 0;
                end else if (r) begin
                    if (m_idx == 7) m_phase = 2;
                    else            m_idx++;
                end
            end
            default: begin
                m_phase = 0;
                m_idx   = 0;
            end
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic check_accepted(bit complete);
        if (complete) chk("acc_count", acc.size(), 8);
        foreach (acc[i]) chk("acc_word", acc[i], i + 1);
    endtask

    initial begin
        bit aborted;
        bit a;
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // Reset state
        step(0, 0, 1);
        step(0, 1, 1);

        // Full scan, ready held high
        acc.delete();
        step(1, 0, 1);
        for (int k = 1; k <= 9; k++) step(0, 0, 1);
        chk("full_sum", int'(sum), 36);
        step(0, 0, 1);
        check_accepted(1);

        // Backpressure 1,0,0,1 repeating
        acc.delete();
        step(1, 0, 1);
        for (int k = 0; k < 60 && m_phase != 0; k++) step(0, 0, (k % 4 == 0) || (k % 4 == 3));
        chk("bp_timeout", m_phase, 0);
        chk("bp_sum", int'(sum), 36);
        check_accepted(1);

        // Start ignored while streaming and in the done cycle, honoured in idle
        acc.delete();
        step(1, 0, 1);
        for (int k = 1; k <= 9; k++) step(k == 3 || k == 9, 0, 1);
        check_accepted(1);
        acc.delete();
        step(1, 0, 1);
        chk("restart_sum0", int'(sum), 0);
        for (int k = 11; k <= 19; k++) step(0, 0, 1);
        chk("restart_sum", int'(sum), 36);
        check_accepted(1);

        // Abort at the fourth word, which is still counted
        acc.delete();
        step(1, 0, 1);
        for (int k = 1; k <= 3; k++) step(0, 0, 1);
        step(0, 1, 1);
        chk("abort_sum", int'(sum), 10);
        chk("abort_adr", int'(rom_adr), 0);
        step(0, 0, 1);
        step(0, 0, 1);
        check_accepted(0);

        // Asynchronous reset mid-scan
        step(1, 0, 1);
        for (int k = 1; k <= 4; k++) step(0, 0, 1);
        start = 1'b0;
        abort = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_busy",  int'(busy),      0);
        chk("arst_sum",   int'(sum),       0);
        chk("arst_adr",   int'(rom_adr),   0);
        chk("arst_data",  int'(out_data),  0);
        #2;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        acc.delete();
        step(1, 0, 1);
        for (int k = 1; k <= 9; k++) step(0, 0, 1);
        chk("post_rst_sum", int'(sum), 36);
        check_accepted(1);

        // Randomized scans with random backpressure, stray starts and occasional aborts
        for (int n = 0; n < 6; n++) begin
            acc.delete();
            aborted = 1'b0;
            step(1, 0, 1'($urandom));
            for (int k = 0; k < 80 && m_phase != 0; k++) begin
                a = ($urandom_range(0, 19) == 0);
                if (a && m_phase == 1) aborted = 1'b1;
                step(1'($urandom), a, 1'($urandom));
            end
            chk("rnd_timeout", m_phase, 0);
            check_accepted(!aborted);
        end

        // Idle hygiene
        for (int k = 0; k < 20; k++) step(0, 1'($urandom), 1'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
